bellek_erisim_birimi: RTL and testbench

Load/store unit sitting directly upstream of l1b_denetleyici. It takes RISC-V byte/half/word load and store operations from the execute stage and turns them into word-aligned requests on the L1 data cache port. Loads get byte-lane extraction with sign or zero extension. The L1 port has no byte mask, so sub-word stores run as a read-modify-write. Misaligned accesses are flagged and never reach the cache.

---
 rtl/bellek_erisim_birimi_pkg.sv | 28 ++
 rtl/bellek_erisim_birimi_bayt_hizalayici.sv | 48 ++++
 rtl/bellek_erisim_birimi.sv | 219 +++++++++++++++++++++
 tb/tb_bellek_erisim_birimi.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bellek_erisim_birimi_pkg.sv
// Shared constants for the load/store unit: access size codes, FSM states
// and the alignment rule used when an operation is accepted.
package bellek_erisim_birimi_pkg;

    localparam logic [1:0] BOYUT_BAYT   = 2'b00;
    localparam logic [1:0] BOYUT_YARIM  = 2'b01;
    localparam logic [1:0] BOYUT_KELIME = 2'b10;

    typedef enum logic [2:0] {
        BOSTA     = 3'd0,
        OKU_ISTEK = 3'd1,
        OKU_BEKLE = 3'd2,
        YAZ_ISTEK = 3'd3,
        SONUC     = 3'd4
    } durum_t;

    // Reserved size code 2'b11 follows the word rule.
    function automatic logic hizasiz_mi(input logic [1:0] boyut, input logic [1:0] adres_alt);
        logic sonuc_s;
        case (boyut)
            BOYUT_BAYT:  sonuc_s = 1'b0;
            BOYUT_YARIM: sonuc_s = adres_alt[0];
            default:     sonuc_s = (adres_alt != 2'b00);
        endcase
        return sonuc_s;
    endfunction

endpackage

// File: rtl/bellek_erisim_birimi_bayt_hizalayici.sv
// Combinational byte-lane logic: extracts and extends a load value from a read
// word, and merges sub-word store data into a read word.
module bayt_hizalayici
    import bellek_erisim_birimi_pkg::*;
#(
    parameter int VERI_BIT = 32
) (
    input  logic [1:0]          bayt_sec,
    input  logic [1:0]          boyut,
    input  logic                isaretsiz,
    input  logic [VERI_BIT-1:0] okunan_kelime,
    input  logic [VERI_BIT-1:0] yazilacak_veri,
    output logic [VERI_BIT-1:0] cikarilan_veri,
    output logic [VERI_BIT-1:0] birlesik_kelime
);

    logic [4:0]          kaydirma_s;
    logic [VERI_BIT-1:0] kaydirilmis_s;
    logic [VERI_BIT-1:0] serit_maske_s;
    logic [VERI_BIT-1:0] yeni_veri_s;

    assign kaydirma_s    = {bayt_sec, 3'b000};
    assign kaydirilmis_s = okunan_kelime >> kaydirma_s;
    assign yeni_veri_s   = yazilacak_veri << kaydirma_s;

    // Load extraction: lane already shifted down, extend by size and sign.
    always_comb begin
        cikarilan_veri = kaydirilmis_s;
        case (boyut)
            BOYUT_BAYT:  cikarilan_veri = {{24{~isaretsiz & kaydirilmis_s[7]}}, kaydirilmis_s[7:0]};
            BOYUT_YARIM: cikarilan_veri = {{16{~isaretsiz & kaydirilmis_s[15]}}, kaydirilmis_s[15:0]};
            default:     cikarilan_veri = kaydirilmis_s;
        endcase
    end

    // Store merge: lane mask selects which bytes come from the new data.
    always_comb begin
        serit_maske_s = 32'hFFFF_FFFF;
        case (boyut)
            BOYUT_BAYT:  serit_maske_s = 32'h0000_00FF << kaydirma_s;
            BOYUT_YARIM: serit_maske_s = 32'h0000_FFFF << kaydirma_s;
            default:     serit_maske_s = 32'hFFFF_FFFF;
        endcase
    end

    assign birlesik_kelime = (okunan_kelime & ~serit_maske_s) | (yeni_veri_s & serit_maske_s);

endmodule

// File: rtl/bellek_erisim_birimi.sv
// Load/store unit: turns byte/half/word operations into word-aligned L1
// requests, with read-modify-write for sub-word stores.
module bellek_erisim_birimi
    import bellek_erisim_birimi_pkg::*;
#(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 islem_gecerli_i,
    output logic                 islem_hazir_o,
    input  logic [ADRES_BIT-1:0] islem_adres_i,
    input  logic                 islem_yaz_i,
    input  logic [1:0]           islem_boyut_i,
    input  logic                 islem_isaretsiz_i,
    input  logic [VERI_BIT-1:0]  islem_veri_i,
    output logic [VERI_BIT-1:0]  sonuc_veri_o,
    output logic                 sonuc_hata_o,
    output logic                 sonuc_gecerli_o,
    input  logic                 sonuc_hazir_i,
    output logic [ADRES_BIT-1:0] port_istek_adres_o,
    output logic                 port_istek_gecerli_o,
    output logic                 port_istek_yaz_o,
    output logic [VERI_BIT-1:0]  port_istek_veri_o,
    input  logic                 port_istek_hazir_i,
    input  logic [VERI_BIT-1:0]  port_veri_i,
    input  logic                 port_veri_gecerli_i,
    output logic                 port_veri_hazir_o
);

    durum_t               durum_r, durum_d;
    logic                 islem_hazir_r, islem_hazir_d;
    logic                 sonuc_gecerli_r, sonuc_gecerli_d;
    logic [VERI_BIT-1:0]  sonuc_veri_r, sonuc_veri_d;
    logic                 sonuc_hata_r, sonuc_hata_d;
    logic                 istek_gecerli_r, istek_gecerli_d;
    logic                 istek_yaz_r, istek_yaz_d;
    logic [ADRES_BIT-1:0] istek_adres_r, istek_adres_d;
    logic [VERI_BIT-1:0]  istek_veri_r, istek_veri_d;
    logic                 veri_hazir_r, veri_hazir_d;
    logic [1:0]           bayt_sec_r, bayt_sec_d;
    logic [1:0]           boyut_r, boyut_d;
    logic                 isaretsiz_r, isaretsiz_d;
    logic                 yaz_r, yaz_d;
    logic [VERI_BIT-1:0]  veri_r, veri_d;
    logic [VERI_BIT-1:0]  cikarilan_s;
    logic [VERI_BIT-1:0]  birlesik_s;

    bayt_hizalayici #(.VERI_BIT(VERI_BIT)) u_hizalayici (
        .bayt_sec        (bayt_sec_r),
        .boyut           (boyut_r),
        .isaretsiz       (isaretsiz_r),
        .okunan_kelime   (port_veri_i),
        .yazilacak_veri  (veri_r),
        .cikarilan_veri  (cikarilan_s),
        .birlesik_kelime (birlesik_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        durum_d         = durum_r;
        islem_hazir_d   = islem_hazir_r;
        sonuc_gecerli_d = sonuc_gecerli_r;
        sonuc_veri_d    = sonuc_veri_r;
        sonuc_hata_d    = sonuc_hata_r;
        istek_gecerli_d = istek_gecerli_r;
        istek_yaz_d     = istek_yaz_r;
        istek_adres_d   = istek_adres_r;
        istek_veri_d    = istek_veri_r;
        veri_hazir_d    = veri_hazir_r;
        bayt_sec_d      = bayt_sec_r;
        boyut_d         = boyut_r;
        isaretsiz_d     = isaretsiz_r;
        yaz_d           = yaz_r;
        veri_d          = veri_r;
        case (durum_r)
            BOSTA: begin
                if (islem_gecerli_i) begin
                    bayt_sec_d    = islem_adres_i[1:0];
                    boyut_d       = islem_boyut_i;
                    isaretsiz_d   = islem_isaretsiz_i;
                    yaz_d         = islem_yaz_i;
                    veri_d        = islem_veri_i;
                    islem_hazir_d = 1'b0;
                    if (hizasiz_mi(islem_boyut_i, islem_adres_i[1:0])) begin
                        durum_d         = SONUC;
                        sonuc_gecerli_d = 1'b1;
                        sonuc_hata_d    = 1'b1;
                        sonuc_veri_d    = '0;
                    end else begin
                        istek_adres_d   = {islem_adres_i[ADRES_BIT-1:2], 2'b00};
                        istek_gecerli_d = 1'b1;
                        // Sub-word stores must read the word first: the L1 port has no byte mask.
                        if (!islem_yaz_i || (islem_boyut_i == BOYUT_BAYT) || (islem_boyut_i == BOYUT_YARIM)) begin
                            durum_d      = OKU_ISTEK;
                            istek_yaz_d  = 1'b0;
                            istek_veri_d = '0;
                        end else begin
                            durum_d      = YAZ_ISTEK;
                            istek_yaz_d  = 1'b1;
                            istek_veri_d = islem_veri_i;
                        end
                    end
                end else begin
                    durum_d = BOSTA;
                end
            end
            OKU_ISTEK: begin
                if (port_istek_hazir_i) begin
                    durum_d         = OKU_BEKLE;
                    istek_gecerli_d = 1'b0;
                    veri_hazir_d    = 1'b1;
                end else begin
                    durum_d = OKU_ISTEK;
                end
            end
            OKU_BEKLE: begin
                if (port_veri_gecerli_i) begin
                    veri_hazir_d = 1'b0;
                    if (yaz_r) begin
                        durum_d         = YAZ_ISTEK;
                        istek_gecerli_d = 1'b1;
                        istek_yaz_d     = 1'b1;
                        istek_veri_d    = birlesik_s;
                    end else begin
                        durum_d         = SONUC;
                        sonuc_gecerli_d = 1'b1;
                        sonuc_hata_d    = 1'b0;
                        sonuc_veri_d    = cikarilan_s;
                    end
                end else begin
                    durum_d = OKU_BEKLE;
                end
            end
            YAZ_ISTEK: begin
                if (port_istek_hazir_i) begin
                    durum_d         = SONUC;
                    istek_gecerli_d = 1'b0;
                    istek_yaz_d     = 1'b0;
                    sonuc_gecerli_d = 1'b1;
                    sonuc_hata_d    = 1'b0;
                    sonuc_veri_d    = '0;
                end else begin
                    durum_d = YAZ_ISTEK;
                end
            end
            SONUC: begin
                if (sonuc_hazir_i) begin
                    durum_d         = BOSTA;
                    sonuc_gecerli_d = 1'b0;
                    sonuc_hata_d    = 1'b0;
                    sonuc_veri_d    = '0;
                    islem_hazir_d   = 1'b1;
                end else begin
                    durum_d = SONUC;
                end
            end
            default: begin
                durum_d         = BOSTA;
                islem_hazir_d   = 1'b1;
                sonuc_gecerli_d = 1'b0;
                sonuc_hata_d    = 1'b0;
                sonuc_veri_d    = '0;
                istek_gecerli_d = 1'b0;
                istek_yaz_d     = 1'b0;
                veri_hazir_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_r         <= BOSTA;
            islem_hazir_r   <= 1'b1;
            sonuc_gecerli_r <= 1'b0;
            sonuc_veri_r    <= '0;
            sonuc_hata_r    <= 1'b0;
            istek_gecerli_r <= 1'b0;
            istek_yaz_r     <= 1'b0;
            istek_adres_r   <= '0;
            istek_veri_r    <= '0;
            veri_hazir_r    <= 1'b0;
            bayt_sec_r      <= 2'b00;
            boyut_r         <= 2'b00;
            isaretsiz_r     <= 1'b0;
            yaz_r           <= 1'b0;
            veri_r          <= '0;
        end else begin
            durum_r         <= durum_d;
            islem_hazir_r   <= islem_hazir_d;
            sonuc_gecerli_r <= sonuc_gecerli_d;
            sonuc_veri_r    <= sonuc_veri_d;
            sonuc_hata_r    <= sonuc_hata_d;
            istek_gecerli_r <= istek_gecerli_d;
            istek_yaz_r     <= istek_yaz_d;
            istek_adres_r   <= istek_adres_d;
            istek_veri_r    <= istek_veri_d;
            veri_hazir_r    <= veri_hazir_d;
            bayt_sec_r      <= bayt_sec_d;
            boyut_r         <= boyut_d;
            isaretsiz_r     <= isaretsiz_d;
            yaz_r           <= yaz_d;
            veri_r          <= veri_d;
        end
    end

    assign islem_hazir_o        = islem_hazir_r;
    assign sonuc_gecerli_o      = sonuc_gecerli_r;
    assign sonuc_veri_o         = sonuc_veri_r;
    assign sonuc_hata_o         = sonuc_hata_r;
    assign port_istek_gecerli_o = istek_gecerli_r;
    assign port_istek_yaz_o     = istek_yaz_r;
    assign port_istek_adres_o   = istek_adres_r;
    assign port_istek_veri_o    = istek_veri_r;
    assign port_veri_hazir_o    = veri_hazir_r;

endmodule

// File: tb/tb_bellek_erisim_birimi.sv
// Self-checking bench for bellek_erisim_birimi: word-level L1 model plus a
// byte-array reference memory for expected load results.
module tb_bellek_erisim_birimi;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk_i, rst_i;
    logic        islem_gecerli_i, islem_hazir_o, islem_yaz_i, islem_isaretsiz_i;
    logic [31:0] islem_adres_i, islem_veri_i;
    logic [1:0]  islem_boyut_i;
    logic [31:0] sonuc_veri_o;
    logic        sonuc_hata_o, sonuc_gecerli_o, sonuc_hazir_i;
    logic [31:0] port_istek_adres_o, port_istek_veri_o, port_veri_i;
    logic        port_istek_gecerli_o, port_istek_yaz_o, port_istek_hazir_i;
    logic        port_veri_gecerli_i, port_veri_hazir_o;

    int kontrol = 0;
    int hata_sayisi = 0;

    logic [31:0] l1_mem [0:63];
    logic [7:0]  ref_bayt [0:255];
    int okuma_sayisi = 0;
    int yazma_sayisi = 0;
    int okuma_gecikme = 0;
    bit l1_iptal = 1'b0;

    bellek_erisim_birimi #(.ADRES_BIT(32), .VERI_BIT(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .islem_gecerli_i(islem_gecerli_i), .islem_hazir_o(islem_hazir_o),
        .islem_adres_i(islem_adres_i), .islem_yaz_i(islem_yaz_i),
        .islem_boyut_i(islem_boyut_i), .islem_isaretsiz_i(islem_isaretsiz_i),
        .islem_veri_i(islem_veri_i),
        .sonuc_veri_o(sonuc_veri_o), .sonuc_hata_o(sonuc_hata_o),
        .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_hazir_i(sonuc_hazir_i),
        .port_istek_adres_o(port_istek_adres_o), .port_istek_gecerli_o(port_istek_gecerli_o),
        .port_istek_yaz_o(port_istek_yaz_o), .port_istek_veri_o(port_istek_veri_o),
        .port_istek_hazir_i(port_istek_hazir_i),
        .port_veri_i(port_veri_i), .port_veri_gecerli_i(port_veri_gecerli_i),
        .port_veri_hazir_o(port_veri_hazir_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // L1 model: requests and data handshakes are sampled at posedge, responses driven at negedge.
    initial begin : l1_model
        bit hs_istek, hs_veri, w, bekleyen;
        logic [31:0] a, d, bekleyen_veri;
        int bekle;
        port_veri_gecerli_i = 1'b0;
        port_veri_i = 32'h0;
        bekleyen = 1'b0;
        bekle = 0;
        bekleyen_veri = 32'h0;
        forever begin
            @(posedge clk_i);
            hs_istek = port_istek_gecerli_o && port_istek_hazir_i && !rst_i;
            hs_veri  = port_veri_gecerli_i && port_veri_hazir_o && !rst_i;
            w = port_istek_yaz_o;
            a = port_istek_adres_o;
            d = port_istek_veri_o;
            @(negedge clk_i);
            if (hs_veri) port_veri_gecerli_i = 1'b0;
            if (hs_istek) begin
                if (w) begin
                    l1_mem[a[7:2]] = d;
                    yazma_sayisi++;
                end else begin
                    okuma_sayisi++;
                    bekleyen = 1'b1;
                    bekle = okuma_gecikme;
                    bekleyen_veri = l1_mem[a[7:2]];
                end
            end
            if (l1_iptal) begin
                bekleyen = 1'b0;
                port_veri_gecerli_i = 1'b0;
            end else if (bekleyen) begin
                if (bekle == 0) begin
                    port_veri_i = bekleyen_veri;
                    port_veri_gecerli_i = 1'b1;
                    bekleyen = 1'b0;
                end else begin
                    bekle--;
                end
            end
        end
    end

    function automatic int bayt_sayisi(input logic [1:0] boyut);
        return (boyut == 2'd0) ? 1 : ((boyut == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit ref_hizasiz(input logic [1:0] boyut, input logic [31:0] adres);
        return (int'(adres[7:0]) % bayt_sayisi(boyut)) != 0;
    endfunction

    function automatic logic [31:0] ref_yukle(input logic [1:0] boyut, input logic isaretsiz, input logic [31:0] adres);
        longint deger;
        int n;
        n = bayt_sayisi(boyut);
        deger = 0;
        for (int i = 0; i < n; i++)
            deger = deger + (longint'(ref_bayt[int'(adres[7:0]) + i]) << (8 * i));
        if (!isaretsiz && n < 4 && deger >= (longint'(1) << (8 * n - 1)))
            deger = deger - (longint'(1) << (8 * n));
        return deger[31:0];
    endfunction

    task automatic ref_yaz(input logic [1:0] boyut, input logic [31:0] adres, input logic [31:0] veri);
        for (int i = 0; i < bayt_sayisi(boyut); i++)
            ref_bayt[int'(adres[7:0]) + i] = veri[8*i +: 8];
    endtask

    task automatic islem_yap(input logic yaz, input logic [1:0] boyut, input logic isaretsiz,
                             input logic [31:0] adres, input logic [31:0] veri,
                             output logic [31:0] sonuc, output logic hata, output int gecikme);
        int n;
        n = 0;
        while (!islem_hazir_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        islem_gecerli_i = 1'b1;
        islem_yaz_i = yaz;
        islem_boyut_i = boyut;
        islem_isaretsiz_i = isaretsiz;
        islem_adres_i = adres;
        islem_veri_i = veri;
        @(posedge clk_i);
        @(negedge clk_i);
        islem_gecerli_i = 1'b0;
        gecikme = 1;
        while (!sonuc_gecerli_o && gecikme < 60) begin
            @(negedge clk_i);
            gecikme++;
        end
        kontrol++;
        if (!sonuc_gecerli_o) begin
            hata_sayisi++;
            $display("FAIL sonuc_zaman_asimi gercek=%0d beklenen<60 adres=%h", gecikme, adres);
        end
        sonuc = sonuc_veri_o;
        hata = sonuc_hata_o;
        @(posedge clk_i);
        @(negedge clk_i);
        if (yaz && !ref_hizasiz(boyut, adres)) ref_yaz(boyut, adres, veri);
    endtask

    task automatic test_reset;
        kontrol++;
        if (islem_hazir_o !== 1'b1 || sonuc_gecerli_o !== 1'b0 || sonuc_veri_o !== 32'h0 ||
            sonuc_hata_o !== 1'b0 || port_istek_gecerli_o !== 1'b0 || port_istek_yaz_o !== 1'b0 ||
            port_istek_adres_o !== 32'h0 || port_istek_veri_o !== 32'h0 || port_veri_hazir_o !== 1'b0) begin
            hata_sayisi++;
            $display("FAIL reset_degerleri gercek=%b_%b_%h_%b_%b_%b_%h_%h_%b beklenen=1_0_0_0_0_0_0_0_0",
                     islem_hazir_o, sonuc_gecerli_o, sonuc_veri_o, sonuc_hata_o, port_istek_gecerli_o,
                     port_istek_yaz_o, port_istek_adres_o, port_istek_veri_o, port_veri_hazir_o);
        end
    endtask

    task automatic dogrula(input string ad, input logic [31:0] veri, input logic hata, input int gecikme,
                           input logic [31:0] bek_veri, input logic bek_hata, input int bek_gecikme);
        kontrol++;
        if (veri !== bek_veri || hata !== bek_hata || gecikme != bek_gecikme) begin
            hata_sayisi++;
            $display("FAIL %s gercek=%h/%b/%0d beklenen=%h/%b/%0d", ad, veri, hata, gecikme, bek_veri, bek_hata, bek_gecikme);
        end
    endtask

    task automatic test_plan;
        logic [31:0] v;
        logic h;
        int g, r0, w0;
        islem_yap(1'b1, 2'd2, 1'b0, BASE + 32'h40, 32'h1122_3344, v, h, g);
        dogrula("sw", v, h, g, 32'h0, 1'b0, 2);
        islem_yap(1'b0, 2'd2, 1'b0, BASE + 32'h40, 32'h0, v, h, g);
        dogrula("lw", v, h, g, 32'h1122_3344, 1'b0, 3);
        r0 = okuma_sayisi;
        w0 = yazma_sayisi;
        islem_yap(1'b1, 2'd0, 1'b0, BASE + 32'h41, 32'h0000_00AB, v, h, g);
        dogrula("sb", v, h, g, 32'h0, 1'b0, 4);
        kontrol++;
        if (okuma_sayisi - r0 != 1 || yazma_sayisi - w0 != 1) begin
            hata_sayisi++;
            $display("FAIL sb_l1_sayilari gercek=%0d/%0d beklenen=1/1", okuma_sayisi - r0, yazma_sayisi - w0);
        end
        islem_yap(1'b0, 2'd2, 1'b0, BASE + 32'h40, 32'h0, v, h, g);
        dogrula("lw_sb_sonrasi", v, h, g, 32'h1122_AB44, 1'b0, 3);
        islem_yap(1'b0, 2'd0, 1'b0, BASE + 32'h41, 32'h0, v, h, g);
        dogrula("lb", v, h, g, 32'hFFFF_FFAB, 1'b0, 3);
        islem_yap(1'b0, 2'd0, 1'b1, BASE + 32'h41, 32'h0, v, h, g);
        dogrula("lbu", v, h, g, 32'h0000_00AB, 1'b0, 3);
        islem_yap(1'b0, 2'd1, 1'b0, BASE + 32'h42, 32'h0, v, h, g);
        dogrula("lh", v, h, g, 32'h0000_1122, 1'b0, 3);
        islem_yap(1'b1, 2'd1, 1'b0, BASE + 32'h42, 32'h0000_8001, v, h, g);
        dogrula("sh", v, h, g, 32'h0, 1'b0, 4);
        islem_yap(1'b0, 2'd1, 1'b0, BASE + 32'h42, 32'h0, v, h, g);
        dogrula("lh_sh_sonrasi", v, h, g, 32'hFFFF_8001, 1'b0, 3);
        islem_yap(1'b0, 2'd2, 1'b0, BASE + 32'h40, 32'h0, v, h, g);
        dogrula("lw_sh_sonrasi", v, h, g, 32'h8001_AB44, 1'b0, 3);
    endtask

    task automatic test_misaligned;
        logic [31:0] v;
        logic h;
        int g, r0, w0;
        r0 = okuma_sayisi;
        w0 = yazma_sayisi;
        islem_yap(1'b0, 2'd2, 1'b0, BASE + 32'h42, 32'h0, v, h, g);
        dogrula("lw_hizasiz", v, h, g, 32'h0, 1'b1, 1);
        islem_yap(1'b0, 2'd1, 1'b0, BASE + 32'h43, 32'h0, v, h, g);
        dogrula("lh_hizasiz", v, h, g, 32'h0, 1'b1, 1);
        islem_yap(1'b1, 2'd3, 1'b0, BASE + 32'h41, 32'hDEAD_BEEF, v, h, g);
        dogrula("sw11_hizasiz", v, h, g, 32'h0, 1'b1, 1);
        kontrol++;
        if (okuma_sayisi != r0 || yazma_sayisi != w0) begin
            hata_sayisi++;
            $display("FAIL hizasiz_l1_istek gercek=%0d/%0d beklenen=0/0", okuma_sayisi - r0, yazma_sayisi - w0);
        end
    endtask

    task automatic test_stall(input logic yaz, input logic [31:0] adres, input logic [31:0] veri,
                              input logic [31:0] bek_sonuc);
        int n;
        port_istek_hazir_i = 1'b0;
        sonuc_hazir_i = 1'b0;
        islem_gecerli_i = 1'b1;
        islem_yaz_i = yaz;
        islem_boyut_i = 2'd2;
        islem_isaretsiz_i = 1'b0;
        islem_adres_i = adres;
        islem_veri_i = veri;
        @(posedge clk_i);
        @(negedge clk_i);
        islem_gecerli_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            kontrol++;
            if (port_istek_gecerli_o !== 1'b1 || port_istek_adres_o !== adres || port_istek_yaz_o !== yaz ||
                (yaz && port_istek_veri_o !== veri)) begin
                hata_sayisi++;
                $display("FAIL istek_kararlilik gercek=%b/%h/%b/%h beklenen=1/%h/%b/%h",
                         port_istek_gecerli_o, port_istek_adres_o, port_istek_yaz_o, port_istek_veri_o, adres, yaz, veri);
            end
            @(negedge clk_i);
        end
        port_istek_hazir_i = 1'b1;
        n = 0;
        while (!sonuc_gecerli_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            kontrol++;
            if (sonuc_gecerli_o !== 1'b1 || sonuc_veri_o !== bek_sonuc || sonuc_hata_o !== 1'b0) begin
                hata_sayisi++;
                $display("FAIL sonuc_kararlilik gercek=%b/%h/%b beklenen=1/%h/0", sonuc_gecerli_o, sonuc_veri_o, sonuc_hata_o, bek_sonuc);
            end
            @(negedge clk_i);
        end
        sonuc_hazir_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        kontrol++;
        if (sonuc_gecerli_o !== 1'b0 || islem_hazir_o !== 1'b1) begin
            hata_sayisi++;
            $display("FAIL sonuc_birakma gercek=%b/%b beklenen=0/1", sonuc_gecerli_o, islem_hazir_o);
        end
        if (yaz) ref_yaz(2'd2, adres, veri);
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        logic h;
        int g, n;
        bit goruldu;
        okuma_gecikme = 4;
        islem_gecerli_i = 1'b1;
        islem_yaz_i = 1'b0;
        islem_boyut_i = 2'd2;
        islem_isaretsiz_i = 1'b0;
        islem_adres_i = BASE + 32'h44;
        islem_veri_i = 32'h0;
        @(posedge clk_i);
        @(negedge clk_i);
        islem_gecerli_i = 1'b0;
        n = 0;
        while (!port_veri_hazir_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        kontrol++;
        if (port_veri_hazir_o !== 1'b1) begin
            hata_sayisi++;
            $display("FAIL oku_bekle_ulasma gercek=%b beklenen=1", port_veri_hazir_o);
        end
        #2 rst_i = 1'b1;
        #1;
        test_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        goruldu = 1'b0;
        repeat (8) begin
            @(negedge clk_i);
            if (sonuc_gecerli_o) goruldu = 1'b1;
        end
        kontrol++;
        if (goruldu) begin
            hata_sayisi++;
            $display("FAIL gec_veri_sonuc gercek=1 beklenen=0");
        end
        l1_iptal = 1'b1;
        repeat (2) @(negedge clk_i);
        l1_iptal = 1'b0;
        okuma_gecikme = 0;
        islem_yap(1'b0, 2'd2, 1'b0, BASE + 32'h44, 32'h0, v, h, g);
        dogrula("reset_sonrasi_lw", v, h, g, ref_yukle(2'd2, 1'b0, BASE + 32'h44), 1'b0, 3);
    endtask

    task automatic test_random;
        logic [31:0] v, adres, veri, bek;
        logic h, yaz, isz;
        logic [1:0] boyut;
        int g, bek_g;
        bit hiz;
        for (int i = 0; i < 60; i++) begin
            adres = BASE + 32'($urandom_range(0, 255));
            boyut = 2'($urandom_range(0, 3));
            yaz = 1'($urandom_range(0, 1));
            isz = 1'($urandom_range(0, 1));
            veri = $urandom;
            hiz = ref_hizasiz(boyut, adres);
            bek = (hiz || yaz) ? 32'h0 : ref_yukle(boyut, isz, adres);
            bek_g = hiz ? 1 : (!yaz ? 3 : (boyut >= 2'd2 ? 2 : 4));
            islem_yap(yaz, boyut, isz, adres, veri, v, h, g);
            dogrula("rastgele", v, h, g, bek, hiz, bek_g);
        end
    endtask

    initial begin
        logic [31:0] w;
        rst_i = 1'b1;
        islem_gecerli_i = 1'b0;
        islem_adres_i = 32'h0;
        islem_yaz_i = 1'b0;
        islem_boyut_i = 2'd0;
        islem_isaretsiz_i = 1'b0;
        islem_veri_i = 32'h0;
        sonuc_hazir_i = 1'b1;
        port_istek_hazir_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            l1_mem[i] = w;
            for (int b = 0; b < 4; b++) ref_bayt[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(negedge clk_i);
        test_reset();
        rst_i = 1'b0;
        @(negedge clk_i);
        test_plan();
        test_misaligned();
        test_stall(1'b1, BASE + 32'h44, 32'hCAFE_F00D, 32'h0);
        test_stall(1'b0, BASE + 32'h44, 32'h0, 32'hCAFE_F00D);
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", kontrol, hata_sayisi);
        $finish;
    end

endmodule
